// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - opcode constants, FSM state encoding and decode helpers
package proc_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_AND   = 4'h3;
    localparam logic [3:0] OP_OR    = 4'h4;
    localparam logic [3:0] OP_LDI   = 4'h5;
    localparam logic [3:0] OP_LOAD  = 4'h6;
    localparam logic [3:0] OP_STORE = 4'h7;
    localparam logic [3:0] OP_JZ    = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    typedef logic [2:0] state_t;

    localparam state_t ST_FETCH  = 3'd0;
    localparam state_t ST_DECODE = 3'd1;
    localparam state_t ST_EXEC   = 3'd2;
    localparam state_t ST_MEM    = 3'd3;
    localparam state_t ST_WB     = 3'd4;
    localparam state_t ST_HALT   = 3'd5;

    // ALU-class opcodes: the only ones allowed to update the zero flag
    function automatic logic op_is_alu(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

    // Opcodes that write register ra in WB
    function automatic logic op_writes_reg(input logic [3:0] op);
        return op_is_alu(op) || (op == OP_LDI) || (op == OP_LOAD);
    endfunction

    // Opcodes that pass through the MEM state
    function automatic logic op_is_mem(input logic [3:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/regfile_p.sv
// rtl/regfile_p.sv - register file, two async read ports, one sync write port
module regfile_p #(
    parameter int DATA_W = 16,
    parameter int NREGS  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_we,
    input  logic [$clog2(NREGS)-1:0]   i_waddr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [$clog2(NREGS)-1:0]   i_raddr_a,
    input  logic [$clog2(NREGS)-1:0]   i_raddr_b,
    output logic [DATA_W-1:0]          o_rdata_a,
    output logic [DATA_W-1:0]          o_rdata_b
);

    logic [DATA_W-1:0] r_mem [NREGS];

    assign o_rdata_a = r_mem[i_raddr_a];
    assign o_rdata_b = r_mem[i_raddr_b];

    // Clear every register on reset, otherwise a single write per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

endmodule

// File: rtl/processor_mc.sv
// rtl/processor_mc.sv - multi-cycle 16-bit-instruction processor core
module processor_mc
    import proc_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NREGS   = 16,
    parameter int DADDR_W = 8,
    parameter int PC_W    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [PC_W-1:0]     imem_addr,
    input  logic [15:0]         imem_data,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W-1:0]   dmem_rdata,
    input  logic                dmem_ack,
    output logic                zero,
    output logic                halted
);

    localparam int RW = $clog2(NREGS);

    state_t              r_state;
    logic [PC_W-1:0]     r_pc;
    logic [15:0]         r_ir;
    logic [DATA_W-1:0]   r_result;
    logic                r_zero;
    logic                r_halted;
    logic                r_dmem_req;
    logic                r_dmem_we;
    logic [DADDR_W-1:0]  r_dmem_addr;
    logic [DATA_W-1:0]   r_dmem_wdata;

    logic [3:0]          w_op;
    logic [RW-1:0]       w_ra;
    logic [RW-1:0]       w_rb;
    logic [RW-1:0]       w_rc;
    logic [7:0]          w_imm8;
    logic [RW-1:0]       w_raddr_a;
    logic [DATA_W-1:0]   w_rdata_a;
    logic [DATA_W-1:0]   w_rdata_b;
    logic [DATA_W-1:0]   w_alu;
    logic                w_rf_we;

    assign w_op   = r_ir[15:12];
    assign w_ra   = r_ir[8 +: RW];
    assign w_rb   = r_ir[4 +: RW];
    assign w_rc   = r_ir[0 +: RW];
    assign w_imm8 = r_ir[7:0];

    // STORE reads its source through port A; everything else reads rb there
    assign w_raddr_a = (w_op == OP_STORE) ? w_ra : w_rb;
    assign w_rf_we   = (r_state == ST_WB) && op_writes_reg(w_op);

    assign imem_addr  = r_pc;
    assign dmem_req   = r_dmem_req;
    assign dmem_we    = r_dmem_we;
    assign dmem_addr  = r_dmem_addr;
    assign dmem_wdata = r_dmem_wdata;
    assign zero       = r_zero;
    assign halted     = r_halted;

    regfile_p #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS)
    ) u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_rf_we),
        .i_waddr   (w_ra),
        .i_wdata   (r_result),
        .i_raddr_a (w_raddr_a),
        .i_raddr_b (w_rc),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    // ALU and immediate path: result that EXEC registers for writeback
    always_comb begin
        w_alu = '0;
        case (w_op)
            OP_ADD:  w_alu = w_rdata_a + w_rdata_b;
            OP_SUB:  w_alu = w_rdata_a - w_rdata_b;
            OP_AND:  w_alu = w_rdata_a & w_rdata_b;
            OP_OR:   w_alu = w_rdata_a | w_rdata_b;
            OP_LDI:  w_alu = DATA_W'(w_imm8);
            default: w_alu = '0;
        endcase
    end

    // Sequencer: FETCH/DECODE/EXEC/(MEM)/WB, plus the memory handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= '0;
            r_ir         <= '0;
            r_result     <= '0;
            r_zero       <= 1'b0;
            r_halted     <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir    <= imem_data;
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    r_result <= w_alu;
                    if (op_is_alu(w_op)) begin
                        r_zero <= (w_alu == '0);
                    end
                    if (w_op == OP_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else if (op_is_mem(w_op)) begin
                        r_dmem_req  <= 1'b1;
                        r_dmem_we   <= (w_op == OP_STORE);
                        r_dmem_addr <= DADDR_W'(w_imm8);
                        if (w_op == OP_STORE) begin
                            r_dmem_wdata <= w_rdata_a;
                        end
                        r_state <= ST_MEM;
                    end else begin
                        r_state <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (dmem_ack && r_dmem_req) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (!r_dmem_we) begin
                            r_result <= dmem_rdata;
                        end
                        r_state <= ST_WB;
                    end
                end
                ST_WB: begin
                    if ((w_op == OP_JZ) && r_zero) begin
                        r_pc <= PC_W'(w_imm8);
                    end else begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                    r_state <= ST_FETCH;
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_processor_mc.sv
// tb/tb_processor_mc.sv - self-checking bench for processor_mc with an ISA-level model
module tb_processor_mc;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int AW = 8;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [PW-1:0] imem_addr;
    logic [15:0]   imem_data = '0;
    logic          dmem_req;
    logic          dmem_we;
    logic [AW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;
    logic          dmem_ack = 1'b0;
    logic          zero;
    logic          halted;

    int checks = 0;
    int failures = 0;

    logic [15:0] imem [256];
    logic [15:0] dmem [256];

    int m_regs [NR];
    int m_mem  [256];
    int m_pc;
    bit m_zero;
    bit m_halted;

    int cur_delay = 0;
    int wait_cnt = 0;
    bit ack_given = 0;
    bit spurious = 0;

    int          mon_run = 0;
    bit          mon_stable = 1;
    logic [7:0]  mon_addr;
    logic [15:0] mon_wdata;
    logic        mon_we;

    processor_mc #(
        .DATA_W  (DW),
        .NREGS   (NR),
        .DADDR_W (AW),
        .PC_W    (PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .zero       (zero),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    // Instruction memory with one cycle of read latency
    always @(negedge clk) imem_data = imem[imem_addr];

    // Data memory responder: ack after cur_delay waiting cycles
    always @(negedge clk) begin
        dmem_ack = 1'b0;
        if (spurious) begin
            dmem_ack = 1'b1;
        end else if (!dmem_req) begin
            wait_cnt  = 0;
            ack_given = 0;
        end else if (!ack_given) begin
            if (wait_cnt >= cur_delay) begin
                dmem_ack  = 1'b1;
                ack_given = 1;
                if (dmem_we) dmem[dmem_addr] = dmem_wdata;
                else         dmem_rdata = dmem[dmem_addr];
            end else begin
                wait_cnt++;
            end
        end
    end

    // Request monitor: length of the req-high run and stability of addr/we/wdata
    always @(negedge clk) begin
        if (dmem_req) begin
            if (mon_run == 0) begin
                mon_addr  = dmem_addr;
                mon_wdata = dmem_wdata;
                mon_we    = dmem_we;
            end else if (dmem_addr !== mon_addr || dmem_wdata !== mon_wdata || dmem_we !== mon_we) begin
                mon_stable = 0;
            end
            mon_run++;
        end
    end

    function automatic logic [15:0] ins_r(input int op, input int ra, input int rb, input int rc);
        return {op[3:0], ra[3:0], rb[3:0], rc[3:0]};
    endfunction

    function automatic logic [15:0] ins_i(input int op, input int ra, input int imm);
        return {op[3:0], ra[3:0], imm[7:0]};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic init_dmem();
        for (int i = 0; i < 256; i++) begin
            dmem[i]  = 16'($urandom);
            m_mem[i] = int'(dmem[i]);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        spurious  = 0;
        cur_delay = 0;
        m_pc      = 0;
        m_zero    = 0;
        m_halted  = 0;
        for (int i = 0; i < NR; i++) m_regs[i] = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Executes n instructions on the model and checks PC timing, flags and memory traffic
    task automatic run_steps(input int n, input int fdelay);
        for (int s = 0; s < n && !m_halted; s++) begin
            logic [15:0] ins;
            int op, ra, rb, rc, imm, old_pc, dly, cyc, res, st_data;
            bit is_mem;
            ins = imem[m_pc];
            op = int'(ins[15:12]); ra = int'(ins[11:8]); rb = int'(ins[7:4]);
            rc = int'(ins[3:0]);   imm = int'(ins[7:0]);
            old_pc = m_pc;
            if (op == 15) begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                checks++;
                if (halted !== 1'b0) begin
                    failures++; $display("FAIL halt_early pc=%0h got=%0b expected=0", old_pc, halted);
                end
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (halted !== 1'b1) begin
                    failures++; $display("FAIL halt_set pc=%0h got=%0b expected=1", old_pc, halted);
                end
                checks++;
                if (imem_addr !== old_pc[7:0]) begin
                    failures++; $display("FAIL halt_pc got=%0h expected=%0h", imem_addr, old_pc);
                end
                m_halted = 1;
            end else begin
                is_mem  = (op == 6) || (op == 7);
                dly     = (fdelay >= 0) ? fdelay : int'($urandom_range(0, 4));
                cur_delay = dly;
                st_data = m_regs[ra];
                res = 0;
                case (op)
                    1: res = (m_regs[rb] + m_regs[rc]) & 16'hFFFF;
                    2: res = (m_regs[rb] - m_regs[rc]) & 16'hFFFF;
                    3: res = m_regs[rb] & m_regs[rc];
                    4: res = m_regs[rb] | m_regs[rc];
                    5: res = imm;
                    6: res = m_mem[imm];
                    default: res = 0;
                endcase
                if (op >= 1 && op <= 6) m_regs[ra] = res;
                if (op >= 1 && op <= 4) m_zero = (res == 0);
                if (op == 7) m_mem[imm] = st_data;
                if (op == 8 && m_zero) m_pc = imm;
                else                   m_pc = (m_pc + 1) % 256;
                cyc = 4 + (is_mem ? dly + 1 : 0);
                mon_run = 0;
                mon_stable = 1;
                repeat (cyc - 1) @(posedge clk);
                @(negedge clk);
                checks++;
                if (imem_addr !== old_pc[7:0]) begin
                    failures++; $display("FAIL pc_hold op=%0h got=%0h expected=%0h", op, imem_addr, old_pc);
                end
                @(posedge clk);
                @(negedge clk);
                checks++;
                if (imem_addr !== m_pc[7:0]) begin
                    failures++; $display("FAIL pc_next op=%0h got=%0h expected=%0h", op, imem_addr, m_pc);
                end
                checks++;
                if (zero !== m_zero) begin
                    failures++; $display("FAIL zero_flag op=%0h got=%0b expected=%0b", op, zero, m_zero);
                end
                if (is_mem) begin
                    checks++;
                    if (mon_run != dly + 1) begin
                        failures++; $display("FAIL req_len op=%0h got=%0d expected=%0d", op, mon_run, dly + 1);
                    end
                    checks++;
                    if (!mon_stable || mon_addr !== imm[7:0] || mon_we !== (op == 7)) begin
                        failures++;
                        $display("FAIL req_fields stable=%0b addr=%0h we=%0b expected addr=%0h we=%0b",
                                 mon_stable, mon_addr, mon_we, imm, (op == 7));
                    end
                    if (op == 7) begin
                        checks++;
                        if (mon_wdata !== st_data[15:0]) begin
                            failures++; $display("FAIL store_data got=%0h expected=%0h", mon_wdata, st_data);
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dut.u_regfile.r_mem[i] !== m_regs[i][15:0]) begin
                failures++;
                $display("FAIL %s_r%0d got=%0h expected=%0h", tag, i, dut.u_regfile.r_mem[i], m_regs[i][15:0]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (imem_addr !== 8'h00 || halted !== 1'b0 || zero !== 1'b0) begin
            failures++; $display("FAIL reset_core pc=%0h halted=%0b zero=%0b expected 0/0/0", imem_addr, halted, zero);
        end
        checks++;
        if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || dmem_addr !== 8'h00 || dmem_wdata !== 16'h0000) begin
            failures++;
            $display("FAIL reset_dmem req=%0b we=%0b addr=%0h wdata=%0h expected all 0",
                     dmem_req, dmem_we, dmem_addr, dmem_wdata);
        end
        do_reset();
        compare_regs("reset");
    endtask

    task automatic test_basic();
        clear_imem();
        imem[0] = ins_i(5, 1, 5);
        imem[1] = ins_i(5, 2, 3);
        imem[2] = ins_r(1, 3, 1, 2);
        imem[3] = 16'hF000;
        do_reset();
        run_steps(10, -1);
        checks++;
        if (dut.u_regfile.r_mem[3] !== 16'd8 || zero !== 1'b0) begin
            failures++; $display("FAIL basic_add r3=%0h zero=%0b expected 8/0", dut.u_regfile.r_mem[3], zero);
        end
        compare_regs("basic");
    endtask

    task automatic test_wrap_arith();
        clear_imem();
        imem[0] = ins_i(5, 1, 1);
        imem[1] = ins_r(2, 1, 0, 1);
        imem[2] = ins_r(1, 3, 1, 1);
        imem[3] = ins_r(2, 4, 1, 1);
        imem[4] = 16'hF000;
        do_reset();
        run_steps(10, -1);
        checks++;
        if (dut.u_regfile.r_mem[3] !== 16'hFFFE) begin
            failures++; $display("FAIL add_wrap r3=%0h expected fffe", dut.u_regfile.r_mem[3]);
        end
        checks++;
        if (dut.u_regfile.r_mem[4] !== 16'h0000 || zero !== 1'b1) begin
            failures++; $display("FAIL sub_zero r4=%0h zero=%0b expected 0/1", dut.u_regfile.r_mem[4], zero);
        end
        compare_regs("wrap");
    endtask

    task automatic test_mem();
        init_dmem();
        clear_imem();
        imem[0] = ins_i(5, 1, 5);
        imem[1] = ins_i(5, 2, 3);
        imem[2] = ins_r(1, 3, 1, 2);
        imem[3] = ins_i(7, 3, 8'h20);
        imem[4] = ins_i(6, 5, 8'h20);
        imem[5] = 16'hF000;
        do_reset();
        run_steps(3, -1);
        run_steps(1, 3);
        checks++;
        if (dmem[8'h20] !== 16'd8) begin
            failures++; $display("FAIL store_mem got=%0h expected=8", dmem[8'h20]);
        end
        run_steps(5, -1);
        checks++;
        if (dut.u_regfile.r_mem[5] !== 16'd8) begin
            failures++; $display("FAIL load_r5 got=%0h expected=8", dut.u_regfile.r_mem[5]);
        end
        compare_regs("mem");
    endtask

    task automatic test_jump();
        clear_imem();
        imem[0]     = ins_i(5, 1, 7);
        imem[1]     = ins_r(2, 4, 1, 1);
        imem[2]     = ins_i(8, 0, 8'h10);
        imem[8'h10] = ins_r(1, 3, 1, 1);
        imem[8'h11] = ins_i(8, 0, 8'h30);
        imem[8'h12] = ins_r(2, 4, 1, 1);
        imem[8'h13] = ins_i(8, 0, 8'hFF);
        do_reset();
        run_steps(3, -1);
        checks++;
        if (imem_addr !== 8'h10) begin
            failures++; $display("FAIL jz_taken got=%0h expected=10", imem_addr);
        end
        run_steps(2, -1);
        checks++;
        if (imem_addr !== 8'h12) begin
            failures++; $display("FAIL jz_not_taken got=%0h expected=12", imem_addr);
        end
        run_steps(3, -1);
        checks++;
        if (imem_addr !== 8'h00) begin
            failures++; $display("FAIL pc_wrap got=%0h expected=0", imem_addr);
        end
        compare_regs("jump");
    endtask

    task automatic test_reset_in_mem();
        init_dmem();
        dmem[8'h40]  = 16'h1234;
        m_mem[8'h40] = 32'h1234;
        clear_imem();
        imem[0] = ins_i(6, 5, 8'h40);
        imem[1] = 16'hF000;
        do_reset();
        cur_delay = 20;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1) begin
            failures++; $display("FAIL req_waiting got=%0b expected=1", dmem_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_addr !== 8'h00) begin
            failures++; $display("FAIL req_abort req=%0b pc=%0h expected 0/0", dmem_req, imem_addr);
        end
        @(negedge clk);
        checks++;
        if (dut.u_regfile.r_mem[5] !== 16'h0000) begin
            failures++; $display("FAIL abort_no_wb r5=%0h expected=0", dut.u_regfile.r_mem[5]);
        end
        do_reset();
        run_steps(1, 2);
        checks++;
        if (dut.u_regfile.r_mem[5] !== 16'h1234) begin
            failures++; $display("FAIL reload_r5 got=%0h expected=1234", dut.u_regfile.r_mem[5]);
        end
    endtask

    task automatic test_halt();
        clear_imem();
        imem[0] = ins_i(5, 1, 9);
        imem[1] = 16'hF000;
        imem[2] = ins_i(5, 1, 3);
        do_reset();
        run_steps(5, -1);
        spurious = 1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (dmem_req !== 1'b0 || halted !== 1'b1 || imem_addr !== 8'h01) begin
                failures++;
                $display("FAIL halt_hold req=%0b halted=%0b pc=%0h expected 0/1/01", dmem_req, halted, imem_addr);
            end
        end
        spurious = 0;
        compare_regs("halt");
    endtask

    task automatic test_random();
        int pick;
        for (int it = 0; it < 4; it++) begin
            init_dmem();
            for (int a = 0; a < 256; a++) begin
                pick = int'($urandom_range(0, 99));
                if      (pick < 20) imem[a] = ins_i(5, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
                else if (pick < 50) imem[a] = ins_r(int'($urandom_range(1, 4)), int'($urandom_range(0, 15)),
                                                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                else if (pick < 62) imem[a] = ins_i(6, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
                else if (pick < 74) imem[a] = ins_i(7, int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
                else if (pick < 86) imem[a] = ins_i(8, 0, int'($urandom_range(0, 255)));
                else if (pick < 98) imem[a] = ins_r(int'($urandom_range(9, 14)) & 15, int'($urandom_range(0, 15)),
                                                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
                else                imem[a] = 16'hF000;
            end
            do_reset();
            run_steps(50, -1);
            compare_regs("random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_arith();
        test_mem();
        test_jump();
        test_reset_in_mem();
        test_halt();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/processor_mc.md
PROCESSOR_MC -- requirements
Module: processor_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 16, register/ALU/data-memory word width (8..32).
REQ-002 SHALL have parameter NREGS, default 16, register count (power of 2, 2..16).
REQ-003 SHALL have parameter DADDR_W, default 8, data-memory address width (4..16).
REQ-004 SHALL have parameter PC_W, default 8, instruction-address width (4..16).
REQ-005 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port imem_addr, output, PC_W, instruction address (equals PC).
REQ-008 SHALL have port imem_data, input, 16, instruction word, valid one cycle after imem_addr.
REQ-009 SHALL have port dmem_req, output, 1, data-memory request.
REQ-010 SHALL have port dmem_we, output, 1, request is a write.
REQ-011 SHALL have port dmem_addr, output, DADDR_W, data address.
REQ-012 SHALL have port dmem_wdata, output, DATA_W, write data.
REQ-013 SHALL have port dmem_rdata, input, DATA_W, read data, valid in the ack cycle.
REQ-014 SHALL have port dmem_ack, input, 1, request completion, one cycle per request.
REQ-015 SHALL have port zero, output, 1, ALU zero flag.
REQ-016 SHALL have port halted, output, 1, core stopped.

Function
REQ-017 SHALL decode the instruction as op[15:12], ra[11:8], rb[7:4], rc[3:0], imm8[7:0]; register fields use their low log2(NREGS) bits.
REQ-018 SHALL implement opcodes: 0 NOP, 1 ADD ra=rb+rc, 2 SUB ra=rb-rc, 3 AND, 4 OR, 5 LDI ra=imm8, 6 LOAD ra=mem[imm8], 7 STORE mem[imm8]=ra, 8 JZ pc=imm8 if zero, F HALT; all others execute as NOP.
REQ-019 SHALL run the FSM FETCH -> DECODE -> EXEC -> (MEM for LOAD/STORE) -> WB -> FETCH; HALT enters state HALT from EXEC.
REQ-020 SHALL latch the instruction register in DECODE; non-memory instructions take 4 cycles, memory instructions 4 cycles plus MEM cycles.
REQ-021 SHALL compute arithmetic modulo 2^DATA_W; imm8 is zero-extended to DATA_W, and zero-extended or truncated to the low bits for DADDR_W and PC_W.
REQ-022 SHALL update zero only on ADD/SUB/AND/OR (result == 0), otherwise hold it.
REQ-023 SHALL set PC to PC+1 modulo 2^PC_W in WB, or to imm8 when a JZ is taken.
REQ-024 SHALL assert dmem_req from MEM entry with addr/we/wdata stable until the cycle dmem_ack is sampled high, and deassert it the following cycle.
REQ-025 SHALL capture dmem_rdata on the ack cycle for LOAD, write ra in WB, and ignore dmem_ack while dmem_req is low.
REQ-026 SHALL, in HALT, hold all state, assert halted, and issue no requests until reset.

Reset
REQ-027 SHALL, on rst_n low (asynchronous), force state FETCH, PC 0, all registers 0, zero 0, halted 0, dmem_req 0, dmem_we 0, and dmem_addr/dmem_wdata 0.
REQ-028 SHALL abort any in-flight memory request on reset with no register writeback; the first fetch after release is from address 0.

Structure
REQ-029 SHALL place the opcode constants and the FSM state type in shared package proc_pkg.
REQ-030 SHALL implement the register file as sub-module regfile_p (parameters DATA_W, NREGS; two async read ports, one sync write port).

Verification
REQ-031 SHALL verify: LDI r1,5; LDI r2,3; ADD r3,r1,r2 -> r3=8, zero=0, each instruction 4 cycles.
REQ-032 SHALL verify: DATA_W=16, r1=0xFFFF, ADD r3,r1,r1 -> r3=0xFFFE; SUB r4,r1,r1 -> r4=0, zero=1.
REQ-033 SHALL verify: STORE r3,0x20 with ack delayed 3 cycles -> dmem_req high 4 cycles, addr 0x20 and wdata 8 stable; LOAD r5,0x20 -> r5=8.
REQ-034 SHALL verify: zero=1, JZ 0x10 -> next imem_addr 0x10; zero=0 -> PC+1; PC=0xFF NOP -> PC wraps to 0x00.
REQ-035 SHALL verify: rst_n low during MEM wait -> dmem_req drops the same cycle, destination register unchanged, fetch restarts at 0.
REQ-036 SHALL verify: HALT -> halted=1 from the cycle after EXEC, imem_addr frozen, spurious dmem_ack ignored.
